// File: rtl/stream_to_mem_writer_if.sv
// Bundled command, stream, memory-write and status signals of the stream-to-memory writer.
// The slave modport is the writer itself; the master modport is its environment.
interface stream_to_mem_writer_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  s_valid;
  logic                  s_ready;
  logic [WORD_WIDTH-1:0] s_data;
  logic                  s_last;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_data;

  logic                  sts_valid;
  logic                  sts_ready;
  logic [LEN_WIDTH-1:0]  sts_count;
  logic                  sts_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, s_valid, s_data, s_last, mem_ready, sts_ready,
    input  cmd_ready, s_ready, mem_valid, mem_addr, mem_data, sts_valid, sts_count, sts_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, s_valid, s_data, s_last, mem_ready, sts_ready,
    output cmd_ready, s_ready, mem_valid, mem_addr, mem_data, sts_valid, sts_count, sts_err
  );
endinterface

// File: rtl/stream_to_mem_writer.sv
// Sinks a valid/ready word stream into consecutive memory word addresses for one command
// (base address, length), then reports words written and whether packet framing matched.
module stream_to_mem_writer #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  stream_to_mem_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DRAIN  = 2'd2,
    STATUS = 2'd3
  } state_t;

  state_t                state_q;
  logic                  cmdReady_q;
  logic                  memValid_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [WORD_WIDTH-1:0] memData_q;
  logic                  stsValid_q;
  logic [LEN_WIDTH-1:0]  stsCount_q;
  logic                  stsErr_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] wrAddr_d;
  logic [LEN_WIDTH-1:0]  remaining_d;
  logic [LEN_WIDTH-1:0]  count_d;
  logic                  memHs;
  logic                  sReady;
  logic                  streamHs;
  logic                  lastWord;

  // The output stage may take a new word whenever it is empty or retiring this cycle.
  assign memHs       = memValid_q && bus.mem_ready;
  assign sReady      = (state_q == WRITE) && (!memValid_q || bus.mem_ready);
  assign streamHs    = bus.s_valid && sReady;
  assign lastWord    = (remaining_q == LEN_WIDTH'(1));
  assign wrAddr_d    = wrAddr_q + ADDR_WIDTH'(1);
  assign remaining_d = remaining_q - LEN_WIDTH'(1);
  assign count_d     = count_q + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmdReady_q  <= 1'b0;
      memValid_q  <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      stsValid_q  <= 1'b0;
      stsCount_q  <= '0;
      stsErr_q    <= 1'b0;
      wrAddr_q    <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cmdReady_q) begin
            cmdReady_q <= 1'b1;
          end else if (bus.cmd_valid) begin
            cmdReady_q  <= 1'b0;
            wrAddr_q    <= bus.cmd_addr;
            remaining_q <= bus.cmd_len;
            count_q     <= '0;
            err_q       <= 1'b0;
            if (bus.cmd_len == '0) begin
              stsValid_q <= 1'b1;
              stsCount_q <= '0;
              stsErr_q   <= 1'b0;
              state_q    <= STATUS;
            end else begin
              state_q <= WRITE;
            end
          end
        end

        WRITE: begin
          // A new word overwrites the retiring one when both handshakes coincide.
          if (streamHs) begin
            memValid_q  <= 1'b1;
            memData_q   <= bus.s_data;
            memAddr_q   <= wrAddr_q;
            wrAddr_q    <= wrAddr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            if (lastWord || bus.s_last) begin
              err_q   <= !(lastWord && bus.s_last);
              state_q <= DRAIN;
            end
          end else if (memHs) begin
            memValid_q <= 1'b0;
          end
        end

        DRAIN: begin
          if (!memValid_q || bus.mem_ready) begin
            memValid_q <= 1'b0;
            stsValid_q <= 1'b1;
            stsCount_q <= count_q;
            stsErr_q   <= err_q;
            state_q    <= STATUS;
          end
        end

        STATUS: begin
          if (bus.sts_ready) begin
            stsValid_q <= 1'b0;
            cmdReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmdReady_q;
  assign bus.s_ready   = sReady;
  assign bus.mem_valid = memValid_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_data  = memData_q;
  assign bus.sts_valid = stsValid_q;
  assign bus.sts_count = stsCount_q;
  assign bus.sts_err   = stsErr_q;

endmodule

// File: tb/tb_stream_to_mem_writer.sv
// Randomized bench for stream_to_mem_writer: a word queue feeds the stream and a simple
// framing model predicts the writes and status for each command.
module tb_stream_to_mem_writer;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stream_to_mem_writer_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  stream_to_mem_writer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  word_t streamQ[$];
  int compared = 0;
  int mismatched = 0;
  int memMode = 0;
  int sValidPct = 100;
  int stsDelay = 0;
  int abortAt = -1;
  int memGaps = 0;

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.mem_ready = 1'b0;
    bus.sts_ready = 1'b0;
  endtask

  task automatic push_packet(input int n, input logic [WW-1:0] first, input bit randomData);
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.data = randomData ? WW'($urandom) : first + WW'(i);
      w.last = (i == n - 1);
      streamQ.push_back(w);
    end
  endtask

  task automatic check_all_zero(input string name);
    compared++;
    if ({bus.cmd_ready, bus.s_ready, bus.mem_valid, bus.sts_valid, bus.mem_addr,
         bus.mem_data, bus.sts_count, bus.sts_err} !== '0) begin
      mismatched++;
      $display("[TB] FAIL %s: outputs rdy/srdy/mv/sv=%b%b%b%b addr=%h data=%h cnt=%0d err=%b, want all 0",
               name, bus.cmd_ready, bus.s_ready, bus.mem_valid, bus.sts_valid,
               bus.mem_addr, bus.mem_data, bus.sts_count, bus.sts_err);
    end
  endtask

  task automatic check_cmd_ready(input string name, input logic want);
    compared++;
    if (bus.cmd_ready !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: cmd_ready=%b want %b", name, bus.cmd_ready, want);
    end
  endtask

  // Runs one command against the current stream queue and checks writes and status.
  task automatic run_command(input logic [AW-1:0] addr, input logic [LW-1:0] len, input string name);
    int p, n, consumed, memCount, stsSeen, lastMemCyc, cyc;
    logic expErr;
    logic [AW-1:0] expAddr[$];
    logic [WW-1:0] expData[$];
    bit cmdDone, stsDone, prevStall, prevSts;
    logic [AW-1:0] prevAddr;
    logic [WW-1:0] prevData;
    logic [LW-1:0] prevCnt;
    logic prevErr;

    p = 0;
    for (int i = 0; i < streamQ.size(); i++) begin
      if (streamQ[i].last) begin
        p = i + 1;
        break;
      end
    end
    if (len == '0) begin
      n = 0;
      expErr = 1'b0;
    end else begin
      n = (int'(len) < p) ? int'(len) : p;
      expErr = (p != int'(len));
    end
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(addr + AW'(i));
      expData.push_back(streamQ[i].data);
    end

    consumed = 0; memCount = 0; stsSeen = 0; lastMemCyc = 0;
    cmdDone = 0; stsDone = 0; prevStall = 0; prevSts = 0;
    prevAddr = '0; prevData = '0; prevCnt = '0; prevErr = 1'b0;

    for (cyc = 0; cyc < 2000 && !stsDone; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = !cmdDone;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      if (streamQ.size() > 0 && $urandom_range(99) < sValidPct) begin
        bus.s_valid = 1'b1;
        bus.s_data  = streamQ[0].data;
        bus.s_last  = streamQ[0].last;
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
      end
      case (memMode)
        0:       bus.mem_ready = 1'b1;
        1:       bus.mem_ready = (cyc % 2 == 0);
        default: bus.mem_ready = 1'($urandom_range(1));
      endcase
      bus.sts_ready = (stsSeen >= stsDelay);
      if (abortAt >= 0 && consumed == abortAt) begin
        reset_n = 1'b0;
        #1;
        check_all_zero({name, "_async_reset"});
        return;
      end
      #1;

      if (prevStall) begin
        compared++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== prevAddr || bus.mem_data !== prevData) begin
          mismatched++;
          $display("[TB] FAIL %s mem_hold: got v=%b %h@%h want v=1 %h@%h", name,
                   bus.mem_valid, bus.mem_data, bus.mem_addr, prevData, prevAddr);
        end
      end
      if (prevSts) begin
        compared++;
        if (bus.sts_valid !== 1'b1 || bus.sts_count !== prevCnt || bus.sts_err !== prevErr) begin
          mismatched++;
          $display("[TB] FAIL %s sts_hold: got v=%b cnt=%0d err=%b want v=1 cnt=%0d err=%b", name,
                   bus.sts_valid, bus.sts_count, bus.sts_err, prevCnt, prevErr);
        end
      end
      compared++;
      if (bus.s_ready === 1'b1 && (!cmdDone || consumed >= n || (bus.mem_valid && !bus.mem_ready))) begin
        mismatched++;
        $display("[TB] FAIL %s s_ready: got 1 want 0 (accepted=%0d consumed=%0d of %0d mv=%b mr=%b)",
                 name, cmdDone, consumed, n, bus.mem_valid, bus.mem_ready);
      end
      if (cmdDone) begin
        compared++;
        if (bus.cmd_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL %s cmd_ready_busy: got %b want 0", name, bus.cmd_ready);
        end
      end
      if (n == 0) begin
        compared++;
        if (bus.mem_valid !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL %s no_write: mem_valid=%b want 0", name, bus.mem_valid);
        end
      end

      if (bus.cmd_valid && bus.cmd_ready) cmdDone = 1;
      if (bus.s_valid && bus.s_ready) begin
        void'(streamQ.pop_front());
        consumed++;
      end
      if (bus.mem_valid && bus.mem_ready) begin
        compared++;
        if (memCount >= n) begin
          mismatched++;
          $display("[TB] FAIL %s extra_write: got %h@%h, only %0d writes expected", name,
                   bus.mem_data, bus.mem_addr, n);
        end else if (bus.mem_addr !== expAddr[memCount] || bus.mem_data !== expData[memCount]) begin
          mismatched++;
          $display("[TB] FAIL %s write[%0d]: got %h@%h want %h@%h", name, memCount,
                   bus.mem_data, bus.mem_addr, expData[memCount], expAddr[memCount]);
        end
        if (memCount > 0 && cyc != lastMemCyc + 1) memGaps++;
        lastMemCyc = cyc;
        memCount++;
      end
      if (bus.sts_valid) begin
        if (bus.sts_ready) begin
          stsDone = 1;
          compared++;
          if (bus.sts_count !== LW'(n) || bus.sts_err !== expErr) begin
            mismatched++;
            $display("[TB] FAIL %s status: got cnt=%0d err=%b want cnt=%0d err=%b", name,
                     bus.sts_count, bus.sts_err, n, expErr);
          end
        end
        stsSeen++;
      end

      prevStall = bus.mem_valid && !bus.mem_ready;
      prevAddr  = bus.mem_addr;
      prevData  = bus.mem_data;
      prevSts   = bus.sts_valid && !bus.sts_ready;
      prevCnt   = bus.sts_count;
      prevErr   = bus.sts_err;
    end

    @(negedge clk);
    idle_inputs();
    compared++;
    if (!stsDone) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: no status handshake within 2000 cycles, want one", name);
    end
    compared++;
    if (memCount != n) begin
      mismatched++;
      $display("[TB] FAIL %s write_count: got %0d want %0d", name, memCount, n);
    end
    compared++;
    if (consumed != n) begin
      mismatched++;
      $display("[TB] FAIL %s consumed: got %0d want %0d", name, consumed, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_cmd_ready("reset_release_before_edge", 1'b0);
    @(negedge clk);
    #1;
    check_cmd_ready("reset_release_after_edge", 1'b1);
  endtask

  task automatic test_basic();
    streamQ.delete();
    push_packet(4, 8'hA1, 0);
    memMode = 0; sValidPct = 100; stsDelay = 0; memGaps = 0;
    run_command(16'h0010, 16'd4, "basic");
    compared++;
    if (memGaps != 0) begin
      mismatched++;
      $display("[TB] FAIL basic back_to_back: got %0d gaps want 0", memGaps);
    end
  endtask

  task automatic test_stall();
    streamQ.delete();
    push_packet(4, 8'hA1, 0);
    memMode = 1; sValidPct = 100; stsDelay = 1;
    run_command(16'h0010, 16'd4, "stall");
  endtask

  task automatic test_framing();
    streamQ.delete();
    memMode = 0; sValidPct = 100; stsDelay = 0;
    push_packet(2, 8'hB1, 0);
    run_command(16'h0100, 16'd3, "too_short");
    push_packet(4, 8'hC1, 0);
    run_command(16'h0200, 16'd2, "too_long");
    run_command(16'h0300, 16'd2, "leftover");
  endtask

  task automatic test_wrap();
    streamQ.delete();
    push_packet(3, 8'hD1, 0);
    memMode = 2; sValidPct = 80; stsDelay = 0;
    run_command(16'hFFFE, 16'd3, "wrap");
  endtask

  task automatic test_zero_len();
    streamQ.delete();
    push_packet(2, 8'hE1, 0);
    memMode = 0; sValidPct = 100; stsDelay = 5;
    run_command(16'h0400, 16'd0, "zero_len");
    compared++;
    if (streamQ.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL zero_len queue: got %0d words left want 2", streamQ.size());
    end
  endtask

  task automatic test_reset_mid();
    streamQ.delete();
    push_packet(6, 8'h61, 0);
    memMode = 0; sValidPct = 100; stsDelay = 0; abortAt = 2;
    run_command(16'h0040, 16'd6, "reset_mid");
    abortAt = -1;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_cmd_ready("reset_mid_release", 1'b0);
    @(negedge clk);
    #1;
    check_cmd_ready("reset_mid_ready", 1'b1);
    streamQ.delete();
    push_packet(2, 8'h71, 0);
    run_command(16'h0080, 16'd2, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      bit hasLast;
      hasLast = 0;
      foreach (streamQ[i]) if (streamQ[i].last) hasLast = 1;
      if (!hasLast || streamQ.size() < 8) push_packet($urandom_range(1, 7), '0, 1);
      memMode = 2;
      sValidPct = $urandom_range(50, 100);
      stsDelay = $urandom_range(0, 2);
      run_command(AW'($urandom), LW'($urandom_range(0, 6)), $sformatf("random%0d", k));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_framing();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
